// File: rtl/regfile_write_scheduler_if.sv
// regfile_write_scheduler_if: requester handshake, clear control and register-file write bus
interface regfile_write_scheduler_if;
    logic [2:0]  req_valid;
    logic [11:0] req_addr;
    logic [47:0] req_data;
    logic [2:0]  req_ready;
    logic        clear_start;
    logic        clear_busy;
    logic        write;
    logic [3:0]  write_select;
    logic [15:0] inputReg;
    modport master (
        output req_valid, req_addr, req_data, clear_start,
        input  req_ready, clear_busy, write, write_select, inputReg
    );
    modport slave (
        input  req_valid, req_addr, req_data, clear_start,
        output req_ready, clear_busy, write, write_select, inputReg
    );
endinterface

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: round-robin write arbiter for three requesters with a 16-entry clear sweep
module regfile_write_scheduler #(
    parameter logic [15:0] CLEAR_VALUE = 16'h0000
) (
    input logic                        clk,
    input logic                        reset,
    regfile_write_scheduler_if.slave   bus
);
    typedef enum logic {RUN, CLEAR} state_t;
    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] data_q, data_d;
    logic [2:0]  grant;
    logic [1:0]  gidx;
    int          idx;
    // Round-robin pick starting after ptr; scanning from farthest to nearest lets the nearest valid win
    always_comb begin
        grant = '0;
        gidx  = ptr_q;
        idx   = 0;
        if (reset && state_q == RUN && !bus.clear_start) begin
            for (int k = 3; k >= 1; k--) begin
                idx = (int'(ptr_q) + k) % 3;
                if (bus.req_valid[idx]) begin
                    grant = 3'b001 << idx;
                    gidx  = 2'(idx);
                end
            end
        end
    end
    assign bus.req_ready    = grant;
    assign bus.clear_busy   = state_q == CLEAR;
    assign bus.write        = wr_q;
    assign bus.write_select = sel_q;
    assign bus.inputReg     = data_q;
    // Next-state: accepted transfer or sweep step becomes next cycle's write; clear_start preempts requests
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        sel_d   = sel_q;
        data_d  = data_q;
        if (state_q == CLEAR) begin
            wr_d    = 1'b1;
            sel_d   = cnt_q;
            data_d  = CLEAR_VALUE;
            cnt_d   = cnt_q + 4'd1;
            state_d = cnt_q == 4'd15 ? RUN : CLEAR;
        end else if (bus.clear_start) begin
            state_d = CLEAR;
            cnt_d   = 4'd0;
        end else if (|grant) begin
            ptr_d  = gidx;
            wr_d   = 1'b1;
            sel_d  = bus.req_addr[{gidx, 2'b00} +: 4];
            data_d = bus.req_data[{gidx, 4'b0000} +: 16];
        end
    end
    // State and registered write port; ptr resets to 2 so requester 0 is searched first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            ptr_q   <= 2'd2;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            sel_q   <= 4'd0;
            data_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb_regfile_write_scheduler: randomized and directed checks against a behavioural model
module tb_regfile_write_scheduler;
    localparam logic [15:0] CV = 16'hA5C3;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_left, m_ptr;
    logic        m_wr;
    logic [3:0]  m_sel;
    logic [15:0] m_data;
    regfile_write_scheduler_if bus ();
    regfile_write_scheduler #(.CLEAR_VALUE(CV)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic int arb(input logic [2:0] v, input int p);
        for (int k = 1; k <= 3; k++)
            if (v[(p + k) % 3]) return (p + k) % 3;
        return -1;
    endfunction
    task automatic model_reset();
        m_left = 0; m_ptr = 2; m_wr = 1'b0; m_sel = 4'd0; m_data = 16'h0000;
    endtask
    task automatic step(input logic [2:0] v, input logic [11:0] a, input logic [47:0] d, input logic c);
        int g;
        logic [2:0] exp_ready;
        bus.req_valid = v; bus.req_addr = a; bus.req_data = d; bus.clear_start = c;
        #1;
        g = arb(v, m_ptr);
        exp_ready = (m_left > 0 || c || g < 0) ? 3'b000 : 3'(3'b001 << g);
        chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        chk("clear_busy", 32'(bus.clear_busy), 32'(m_left > 0));
        chk("write", 32'(bus.write), 32'(m_wr));
        chk("write_select", 32'(bus.write_select), 32'(m_sel));
        chk("inputReg", 32'(bus.inputReg), 32'(m_data));
        @(posedge clk);
        if (m_left > 0) begin
            m_wr = 1'b1; m_sel = 4'(16 - m_left); m_data = CV; m_left--;
        end else if (c) begin
            m_wr = 1'b0; m_left = 16;
        end else if (g >= 0) begin
            m_wr = 1'b1; m_sel = a[g*4 +: 4]; m_data = d[g*16 +: 16]; m_ptr = g;
        end else begin
            m_wr = 1'b0;
        end
        @(negedge clk);
    endtask
    task automatic do_reset();
        bus.req_valid = 3'b111; bus.clear_start = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_write", 32'(bus.write), 32'h0);
        chk("rst_sel", 32'(bus.write_select), 32'h0);
        chk("rst_data", 32'(bus.inputReg), 32'h0);
        chk("rst_busy", 32'(bus.clear_busy), 32'h0);
        @(negedge clk);
        reset = 1'b1;
    endtask
    initial begin
        bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0; bus.clear_start = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();
        step(3'b001, 12'h005, 48'h0000_0000_BEEF, 1'b0);
        step(3'b000, 12'h000, 48'h0, 1'b0);
        chk("single_write", 32'(bus.write), 32'h0);
        chk("single_sel", 32'(bus.write_select), 32'h5);
        chk("single_data", 32'(bus.inputReg), 32'hBEEF);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 3'b111; bus.req_addr = 12'h321; #1;
            chk("rr_grant", 32'(bus.req_ready), 32'(3'b001 << (i % 3)));
            step(3'b111, 12'h321, 48'h3333_2222_1111, 1'b0);
            chk("rr_sel", 32'(bus.write_select), 32'((i % 3) + 1));
        end
        step(3'b111, 12'h321, 48'h3333_2222_1111, 1'b1);
        for (int i = 0; i < 18; i++) step(3'b111, 12'h321, 48'h3333_2222_1111, 1'b0);
        do_reset();
        step(3'b011, 12'h033, 48'h0000_2222_1111, 1'b0);
        chk("same_reg_first", 32'(bus.inputReg), 32'h1111);
        step(3'b010, 12'h033, 48'h0000_2222_1111, 1'b0);
        step(3'b000, 12'h033, 48'h0000_2222_1111, 1'b0);
        chk("same_reg_last", 32'(bus.inputReg), 32'h2222);
        chk("same_reg_sel", 32'(bus.write_select), 32'h3);
        step(3'b000, 12'h0, 48'h0, 1'b1);
        for (int i = 0; i < 8; i++) step(3'b111, 12'h0, 48'h0, 1'b0);
        reset = 1'b0;
        #1;
        model_reset();
        chk("abort_write", 32'(bus.write), 32'h0);
        chk("abort_busy", 32'(bus.clear_busy), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step(3'b010, 12'h0A0, 48'h0000_7777_0000, 1'b0);
        chk("abort_resume_sel", 32'(bus.write_select), 32'hA);
        for (int i = 0; i < 5; i++) step(3'b000, 12'hFFF, 48'hFFFF_FFFF_FFFF, 1'b0);
        for (int i = 0; i < 600; i++)
            step(3'($urandom), 12'($urandom), {16'($urandom), 32'($urandom)}, $urandom_range(0, 19) == 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
